monbus_rr_arbiter: RTL and testbench



---
 rtl/monitor_arb_pkg.sv | 16 +
 rtl/monbus_rr_arbiter_if.sv | 27 ++
 rtl/monbus_rr_pick.sv | 36 +++
 rtl/monbus_rr_arbiter.sv | 116 +++++++++++
 tb/tb_monbus_rr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/monitor_arb_pkg.sv
// Shared types and constants for the monitor-bus arbiter.
package monitor_arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/monbus_rr_arbiter_if.sv
// Source-side and monitor-bus-side handshake bundle for monbus_rr_arbiter.
// slave is the arbiter's view; master is the view of the sources plus the downstream sink.
interface monbus_rr_arbiter_if #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned PKT_WIDTH = 64,
  parameter int unsigned IDX_W     = $clog2(NUM_SRC)
);

  logic [NUM_SRC-1:0]   src_valid;
  logic [PKT_WIDTH-1:0] src_packet [NUM_SRC];
  logic [NUM_SRC-1:0]   src_ready;
  logic                 monbus_valid;
  logic                 monbus_ready;
  logic [PKT_WIDTH-1:0] monbus_packet;
  logic [IDX_W-1:0]     monbus_src;

  modport master (
    output src_valid, src_packet, monbus_ready,
    input  src_ready, monbus_valid, monbus_packet, monbus_src
  );

  modport slave (
    input  src_valid, src_packet, monbus_ready,
    output src_ready, monbus_valid, monbus_packet, monbus_src
  );

endinterface

// File: rtl/monbus_rr_pick.sv
// Combinational picker: rotating priority starting after ptr, or fixed lowest-index priority.
module monbus_rr_pick
  import monitor_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  arb_mode_e          mode,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  function automatic logic [IDX_W-1:0] wrap_idx(logic [IDX_W-1:0] base, int unsigned off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_SRC;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = |req;
    if (mode == ARB_FIXED) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (req[IDX_W'(i)]) gnt_idx = IDX_W'(i);
      end
    end else begin
      // Scan farthest offset first so the nearest requester after ptr is assigned last.
      for (int unsigned off = NUM_SRC; off >= 1; off--) begin
        if (req[wrap_idx(ptr, off)]) gnt_idx = wrap_idx(ptr, off);
      end
    end
  end

endmodule

// File: rtl/monbus_rr_arbiter.sv
// Monitor-bus arbiter: picks one source per cycle into a single registered output stage.
// Define MONBUS_ARB_STATS_EN to build per-source packet and backpressure stall counters.
module monbus_rr_arbiter
  import monitor_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned PKT_WIDTH = 64,
  parameter int unsigned IDX_W     = $clog2(NUM_SRC)
) (
  input  logic                aclk,
  input  logic                areset,
  monbus_rr_arbiter_if.slave  bus,
  input  logic [NUM_SRC-1:0]  cfg_src_mask,
  input  logic                cfg_arb_mode,
  output logic                busy
`ifdef MONBUS_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_pkt_count [NUM_SRC],
  output logic [STAT_W-1:0]   stat_stall_cycles,
  input  logic                cfg_stat_clear
`endif
);

  out_state_e           state_q, state_d;
  logic [PKT_WIDTH-1:0] pkt_q, pkt_d;
  logic [IDX_W-1:0]     src_q, src_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0]   req;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic                 load_ok;
  logic                 load;
  arb_mode_e            mode;

  assign mode    = arb_mode_e'(cfg_arb_mode);
  assign req     = bus.src_valid & cfg_src_mask;
  assign load_ok = (state_q == OUT_EMPTY) || bus.monbus_ready;
  // No acceptance while reset is held, so a reset never swallows a source packet.
  assign load    = load_ok && gnt_valid && !areset;

  monbus_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req),
    .ptr       (rr_ptr_q),
    .mode      (mode),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d       = state_q;
    pkt_d         = pkt_q;
    src_d         = src_q;
    rr_ptr_d      = rr_ptr_q;
    bus.src_ready = '0;
    if (load) begin
      bus.src_ready[gnt_idx] = 1'b1;
      state_d                = OUT_FULL;
      pkt_d                  = bus.src_packet[gnt_idx];
      src_d                  = gnt_idx;
      if (mode == ARB_RR) rr_ptr_d = gnt_idx;
    end else if ((state_q == OUT_FULL) && bus.monbus_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= OUT_EMPTY;
      pkt_q    <= '0;
      src_q    <= '0;
      rr_ptr_q <= IDX_W'(NUM_SRC - 1);
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.monbus_valid  = (state_q == OUT_FULL);
  assign bus.monbus_packet = pkt_q;
  assign bus.monbus_src    = src_q;
  assign busy              = (state_q == OUT_FULL);

`ifdef MONBUS_ARB_STATS_EN
  logic [STAT_W-1:0]  pkt_cnt_q [NUM_SRC];
  logic [STAT_W-1:0]  stall_q;
  logic [NUM_SRC-1:0] src_hs;

  assign src_hs = bus.src_valid & bus.src_ready;

  // Counters saturate; clear wins over a same-cycle increment.
  always_ff @(posedge aclk) begin
    if (areset || cfg_stat_clear) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) pkt_cnt_q[IDX_W'(i)] <= '0;
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (src_hs[IDX_W'(i)] && (pkt_cnt_q[IDX_W'(i)] != '1)) begin
          pkt_cnt_q[IDX_W'(i)] <= pkt_cnt_q[IDX_W'(i)] + 1'b1;
        end
      end
      if (bus.monbus_valid && !bus.monbus_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign stat_pkt_count    = pkt_cnt_q;
  assign stat_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_monbus_rr_arbiter.sv
// Self-checking bench for monbus_rr_arbiter: cycle model plus expected-packet scoreboard.
module tb_monbus_rr_arbiter;
  import monitor_arb_pkg::*;

  localparam int unsigned NUM_SRC   = 4;
  localparam int unsigned PKT_WIDTH = 64;
  localparam int unsigned IDX_W     = 2;

  typedef struct packed {
    logic [IDX_W-1:0]     src;
    logic [PKT_WIDTH-1:0] pkt;
  } exp_t;

  logic               aclk = 1'b0;
  logic               areset;
  logic [NUM_SRC-1:0] cfg_src_mask;
  logic               cfg_arb_mode;
  logic               busy;
`ifdef MONBUS_ARB_STATS_EN
  logic [STAT_W-1:0]  stat_pkt_count [NUM_SRC];
  logic [STAT_W-1:0]  stat_stall_cycles;
  logic               cfg_stat_clear;
`endif

  always #5 aclk = ~aclk;

  monbus_rr_arbiter_if #(
    .NUM_SRC   (NUM_SRC),
    .PKT_WIDTH (PKT_WIDTH),
    .IDX_W     (IDX_W)
  ) bus ();

  monbus_rr_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .PKT_WIDTH (PKT_WIDTH),
    .IDX_W     (IDX_W)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .bus               (bus),
    .cfg_src_mask      (cfg_src_mask),
    .cfg_arb_mode      (cfg_arb_mode),
    .busy              (busy)
`ifdef MONBUS_ARB_STATS_EN
    ,
    .stat_pkt_count    (stat_pkt_count),
    .stat_stall_cycles (stat_stall_cycles),
    .cfg_stat_clear    (cfg_stat_clear)
`endif
  );

  int                   n_checks;
  int                   n_errors;
  int unsigned          seq [NUM_SRC];
  int                   ovr_src;
  logic [PKT_WIDTH-1:0] ovr_pkt;
  bit                   m_full;
  logic [IDX_W-1:0]     m_ptr;
  exp_t                 exp_q [$];
  int unsigned          m_cnt [NUM_SRC];
  int unsigned          m_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PKT_WIDTH-1:0] pkt_of(input int i);
    if (i == ovr_src) return ovr_pkt;
    return {8'(8'hC0 + i), 24'h0, 32'(seq[i])};
  endfunction

  // One clock: present packets, check DUT against the model, advance the model at the edge.
  task automatic step();
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] exp_rdy;
    bit                 ld_ok;
    bit                 found;
    bit                 ld;
    int                 win;
    exp_t               e;
    for (int i = 0; i < NUM_SRC; i++) bus.src_packet[i] = pkt_of(i);
    #1;
    req   = bus.src_valid & cfg_src_mask;
    ld_ok = !m_full || bus.monbus_ready;
    found = 0;
    win   = 0;
    if (cfg_arb_mode) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && req[i]) begin found = 1; win = i; end
      end
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        int j;
        j = (int'(m_ptr) + k) % int'(NUM_SRC);
        if (!found && req[j]) begin found = 1; win = j; end
      end
    end
    ld      = ld_ok && found && !areset;
    exp_rdy = '0;
    if (ld) exp_rdy[win] = 1'b1;
    check_eq("src_ready", 64'(bus.src_ready), 64'(exp_rdy));
    check_eq("monbus_valid", 64'(bus.monbus_valid), 64'(m_full));
    check_eq("busy", 64'(busy), 64'(m_full));
    if (m_full) begin
      check_eq("monbus_packet", bus.monbus_packet, exp_q[0].pkt);
      check_eq("monbus_src", 64'(bus.monbus_src), 64'(exp_q[0].src));
    end
`ifdef MONBUS_ARB_STATS_EN
    for (int i = 0; i < NUM_SRC; i++) begin
      check_eq("stat_pkt_count", 64'(stat_pkt_count[i]), 64'(m_cnt[i]));
    end
    check_eq("stat_stall_cycles", 64'(stat_stall_cycles), 64'(m_stall));
`endif
    @(posedge aclk);
    if (areset) begin
      m_full = 0;
      m_ptr  = IDX_W'(NUM_SRC - 1);
      exp_q.delete();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_stall = 0;
    end else begin
`ifdef MONBUS_ARB_STATS_EN
      if (cfg_stat_clear) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_stall = 0;
      end else begin
        if (ld && m_cnt[win] < 32'hFFFF) m_cnt[win]++;
        if (m_full && !bus.monbus_ready && m_stall < 32'hFFFF) m_stall++;
      end
`endif
      if (m_full && bus.monbus_ready) void'(exp_q.pop_front());
      if (ld) begin
        e.src = IDX_W'(win);
        e.pkt = pkt_of(win);
        exp_q.push_back(e);
        m_full = 1;
        seq[win]++;
        if (!cfg_arb_mode) m_ptr = IDX_W'(win);
      end else if (bus.monbus_ready) begin
        m_full = 0;
      end
    end
    @(negedge aclk);
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    areset            = 1'b1;
    bus.src_valid     = '0;
    bus.monbus_ready  = 1'b0;
    cfg_src_mask      = '1;
    cfg_arb_mode      = 1'b0;
    ovr_src           = -1;
    ovr_pkt           = '0;
`ifdef MONBUS_ARB_STATS_EN
    cfg_stat_clear    = 1'b0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      seq[i]            = 0;
      m_cnt[i]          = 0;
      bus.src_packet[i] = '0;
    end
    m_full  = 0;
    m_ptr   = IDX_W'(NUM_SRC - 1);
    m_stall = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);

    check_eq("rst_valid", 64'(bus.monbus_valid), 64'd0);
    check_eq("rst_packet", bus.monbus_packet, 64'd0);
    check_eq("rst_src", 64'(bus.monbus_src), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    // Requests during reset must not be accepted.
    bus.src_valid    = '1;
    bus.monbus_ready = 1'b1;
    step();
    step();

    // Round-robin with all sources valid and no backpressure.
    areset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("rr_seq", 64'(bus.monbus_src), 64'(k % int'(NUM_SRC)));
      check_eq("rr_valid", 64'(bus.monbus_valid), 64'd1);
    end

    bus.src_valid = '0;
`ifdef MONBUS_ARB_STATS_EN
    cfg_stat_clear = 1'b1;
`endif
    step();
`ifdef MONBUS_ARB_STATS_EN
    cfg_stat_clear = 1'b0;
`endif

    // Backpressure holds a packet from source 2.
    ovr_src          = 2;
    ovr_pkt          = 64'hDEAD_0001;
    bus.src_valid    = 4'b0100;
    bus.monbus_ready = 1'b0;
    step();
    ovr_src = -1;
    repeat (5) begin
      step();
      check_eq("hold_pkt", bus.monbus_packet, 64'hDEAD_0001);
      check_eq("hold_src", 64'(bus.monbus_src), 64'd2);
    end
`ifdef MONBUS_ARB_STATS_EN
    check_eq("stall_cnt", 64'(stat_stall_cycles), 64'd5);
`endif
    bus.monbus_ready = 1'b1;
    step();
    bus.src_valid = '0;
    step();

    // Fixed priority: source 1 beats source 3 until it drops.
    cfg_arb_mode  = 1'b1;
    bus.src_valid = 4'b1010;
    repeat (4) begin
      step();
      check_eq("fixed_win", 64'(bus.monbus_src), 64'd1);
    end
    bus.src_valid = 4'b1000;
    repeat (2) begin
      step();
      check_eq("fixed_low", 64'(bus.monbus_src), 64'd3);
    end
    bus.src_valid = '0;
    step();

    // Masked source is never accepted; unmasking releases it.
    cfg_arb_mode  = 1'b0;
    cfg_src_mask  = 4'b1011;
    bus.src_valid = 4'b0100;
    repeat (3) begin
      step();
      check_eq("mask_valid", 64'(bus.monbus_valid), 64'd0);
      check_eq("mask_rdy", 64'(bus.src_ready), 64'd0);
    end
    cfg_src_mask = '1;
    step();
    check_eq("unmask_valid", 64'(bus.monbus_valid), 64'd1);
    check_eq("unmask_src", 64'(bus.monbus_src), 64'd2);

    // Config change while held, then reset while full.
    bus.monbus_ready = 1'b0;
    cfg_arb_mode     = 1'b1;
    step();
    cfg_arb_mode = 1'b0;
    step();
    areset = 1'b1;
    step();
    check_eq("rst_full_valid", 64'(bus.monbus_valid), 64'd0);
    check_eq("rst_full_busy", 64'(busy), 64'd0);
    areset           = 1'b0;
    bus.src_valid    = '1;
    bus.monbus_ready = 1'b1;
    step();
    check_eq("post_rst_src", 64'(bus.monbus_src), 64'd0);

`ifdef MONBUS_ARB_STATS_EN
    // Saturation of the source 0 counter, then clear beating a same-cycle increment.
    bus.src_valid = 4'b0001;
    repeat (70000) step();
    check_eq("sat_cnt", 64'(stat_pkt_count[0]), 64'hFFFF);
    cfg_stat_clear = 1'b1;
    step();
    cfg_stat_clear = 1'b0;
    check_eq("clr_cnt", 64'(stat_pkt_count[0]), 64'd0);
`endif

    bus.src_valid = '0;
    step();
    step();
    check_eq("drain_empty", 64'(bus.monbus_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
